// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small FIFO absorbs producer bursts while the serialiser
// emits back-to-back frames (start, data LSB first, optional parity, stop bits).
module uart_tx_buffered #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned PARITY_TYPE  = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [BITS_N-1:0]             data_tx,
  input  logic                          valid,
  output logic                          ready,
  output logic                          uart_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FcW  = PtrW + 1;

  localparam logic [CntW-1:0] BaudMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [FcW-1:0]  DepthVal = FcW'(FIFO_DEPTH);
  localparam logic [3:0]      LastBit  = 4'(BITS_N - 1);
  localparam logic            LastStop = (STOP_BITS == 2);
  localparam logic            HasPar   = (PARITY_TYPE != 0);
  localparam logic            OddPar   = (PARITY_TYPE == 1);

  if (CLKS_PER_BIT < 2 || BITS_N < 5 || BITS_N > 9 || PARITY_TYPE > 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_param_check
    $error("uart_tx_buffered: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [BITS_N-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FcW-1:0]    count_q, count_d;
  logic              push;
  logic              pop;
  logic [BITS_N-1:0] head;

  // ready depends only on registered occupancy, never on a same-cycle pop
  assign ready = (count_q != DepthVal);
  assign push  = valid && ready;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data_tx;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [CntW-1:0]   baud_cnt_q, baud_cnt_d;
  logic [3:0]        bit_idx_q, bit_idx_d;
  logic              stop_idx_q, stop_idx_d;
  logic [BITS_N-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tick;
  logic              frame_end;
  logic              fifo_nonempty;

  assign fifo_nonempty = (count_q != '0);
  assign tick          = (state_q != StIdle) && (baud_cnt_q == BaudMax);
  assign frame_end     = (state_q == StStop) && tick && (stop_idx_q == LastStop);
  assign pop           = ((state_q == StIdle) || frame_end) && fifo_nonempty;

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    baud_cnt_d = (state_q == StIdle || tick) ? '0 : baud_cnt_q + 1'b1;

    // Latching the head also fixes the parity bit for the whole frame.
    if (pop) begin
      shift_d  = head;
      parity_d = OddPar ? ~^head : ^head;
    end

    case (state_q)
      StIdle: begin
        if (pop) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LastBit) begin
            state_d    = HasPar ? StParity : StStop;
            stop_idx_d = 1'b0;
          end else begin
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          state_d    = StStop;
          stop_idx_d = 1'b0;
        end
      end
      StStop: begin
        if (tick) begin
          if (stop_idx_q == LastStop) begin
            state_d = pop ? StStart : StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
    end
  end

  // Line decoded straight from state so reset forces it high without waiting for a clock.
  always_comb begin
    uart_out = 1'b1;
    case (state_q)
      StStart:  uart_out = 1'b0;
      StData:   uart_out = shift_q[0];
      StParity: uart_out = parity_q;
      default:  uart_out = 1'b1;
    endcase
  end

  assign busy       = (state_q != StIdle) || fifo_nonempty;
  assign frame_done = frame_end;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Bench for uart_tx_buffered: three differently parameterised instances share one random
// stimulus stream and are compared every cycle against a frame-level queue model.
module tb_uart_tx_buffered;

  localparam int NI = 3;
  localparam int CPB [NI] = '{4, 3, 2};
  localparam int NB  [NI] = '{8, 7, 9};
  localparam int PAR [NI] = '{0, 1, 2};
  localparam int STP [NI] = '{1, 2, 2};
  localparam int DEP [NI] = '{4, 2, 8};

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic [8:0]    din;
  logic [NI-1:0] rdy;
  logic [NI-1:0] uo;
  logic [NI-1:0] bz;
  logic [NI-1:0] fd;
  logic [2:0]    fc0;
  logic [1:0]    fc1;
  logic [3:0]    fc2;

  int n_total;
  int n_bad;

  uart_tx_buffered #(
    .CLKS_PER_BIT(4), .BITS_N(8), .PARITY_TYPE(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .data_tx(din[7:0]), .valid(valid), .ready(rdy[0]),
    .uart_out(uo[0]), .busy(bz[0]), .frame_done(fd[0]), .fifo_count(fc0)
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(3), .BITS_N(7), .PARITY_TYPE(1), .STOP_BITS(2), .FIFO_DEPTH(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .data_tx(din[6:0]), .valid(valid), .ready(rdy[1]),
    .uart_out(uo[1]), .busy(bz[1]), .frame_done(fd[1]), .fifo_count(fc1)
  );

  uart_tx_buffered #(
    .CLKS_PER_BIT(2), .BITS_N(9), .PARITY_TYPE(2), .STOP_BITS(2), .FIFO_DEPTH(8)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .data_tx(din), .valid(valid), .ready(rdy[2]),
    .uart_out(uo[2]), .busy(bz[2]), .frame_done(fd[2]), .fifo_count(fc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: queue of accepted words plus the frame currently on the line.
  int mq  [NI][$];
  bit act [NI];
  int cyc [NI];
  int cur [NI];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int flen(input int k);
    return 1 + NB[k] + ((PAR[k] != 0) ? 1 : 0) + STP[k];
  endfunction

  // Bit idx of the frame carrying word w: start, data LSB first, parity, stops.
  function automatic int exp_bit(input int k, input int w, input int idx);
    int ones;
    if (idx == 0) return 0;
    if (idx <= NB[k]) return (w >> (idx - 1)) & 1;
    if (PAR[k] != 0 && idx == NB[k] + 1) begin
      ones = $countones(w);
      return (PAR[k] == 2) ? (ones % 2) : (1 - (ones % 2));
    end
    return 1;
  endfunction

  function automatic int obs_count(input int k);
    case (k)
      0:       return int'(fc0);
      1:       return int'(fc1);
      default: return int'(fc2);
    endcase
  endfunction

  function automatic bit model_busy();
    for (int k = 0; k < NI; k++) begin
      if (act[k] || mq[k].size() != 0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k].delete();
      act[k] = 1'b0;
      cyc[k] = 0;
      cur[k] = 0;
    end
  endtask

  // Advance the model across one rising edge using the inputs presented before it.
  task automatic model_edge();
    int sz;
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        sz = mq[k].size();
        if (act[k]) begin
          cyc[k]++;
          if (cyc[k] == flen(k) * CPB[k]) act[k] = 1'b0;
        end
        if (!act[k] && sz > 0) begin
          cur[k] = mq[k].pop_front();
          act[k] = 1'b1;
          cyc[k] = 0;
        end
        if (valid && sz < DEP[k]) mq[k].push_back(int'(din) % (1 << NB[k]));
      end
    end
  endtask

  task automatic check_outputs(input string pfx);
    int line;
    int done;
    for (int k = 0; k < NI; k++) begin
      line = act[k] ? exp_bit(k, cur[k], cyc[k] / CPB[k]) : 1;
      done = (act[k] && cyc[k] == flen(k) * CPB[k] - 1) ? 1 : 0;
      check_eq($sformatf("%s_u%0d_line", pfx, k), int'(uo[k]), line);
      check_eq($sformatf("%s_u%0d_done", pfx, k), int'(fd[k]), done);
      check_eq($sformatf("%s_u%0d_busy", pfx, k), int'(bz[k]),
               (act[k] || mq[k].size() != 0) ? 1 : 0);
      check_eq($sformatf("%s_u%0d_ready", pfx, k), int'(rdy[k]),
               (mq[k].size() < DEP[k]) ? 1 : 0);
      check_eq($sformatf("%s_u%0d_count", pfx, k), obs_count(k), mq[k].size());
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    valid = 1'b0;
    while (model_busy() && guard < 3000) begin
      tick();
      guard++;
    end
    check_eq(tag, (guard < 3000) ? 1 : 0, 1);
    repeat (3) tick();
  endtask

  initial begin
    int pv;
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b1;
    valid   = 1'b0;
    din     = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_outputs("rst0");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // Single word from idle, then another after the line has gone quiet.
    valid = 1'b1;
    din   = 9'h0A5;
    tick();
    valid = 1'b0;
    repeat (60) tick();
    valid = 1'b1;
    din   = 9'h007;
    tick();
    valid = 1'b0;
    drain("drain_single");

    // Held valid with an incrementing word: fills every FIFO and runs frames back to back.
    for (int i = 0; i < 40; i++) begin
      valid = 1'b1;
      din   = 9'(9'h010 + i);
      tick();
    end
    drain("drain_burst");

    // Asynchronous reset while instance 0 is inside data bit 3 with words still queued.
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      din   = 9'($urandom);
      tick();
    end
    valid = 1'b0;
    repeat (17) tick();
    #1 rst_n = 1'b0;
    #1 model_reset();
    check_outputs("rst_mid");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (100) tick();

    // Random traffic at varying offered load.
    for (int i = 0; i < 1500; i++) begin
      pv    = (i < 500) ? 70 : ((i < 1000) ? 15 : 45);
      valid = ($urandom_range(0, 99) < pv);
      din   = 9'($urandom);
      tick();
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
